dm_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter; responder on CPU32's data-memory bus (dmAddress/dmWidth/dmWrite/dmDataOut).

---
 rtl/dm_uart_tx_pkg.sv | 40 ++++
 rtl/dm_uart_tx_fifo.sv | 53 +++++
 rtl/dm_uart_tx.sv | 249 ++++++++++++++++++++++++
 tb/tb_dm_uart_tx.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: bus widths, register
// offsets within the 16-byte window, STATUS bit positions, TX FSM state encoding and
// the baud divisor clamp helper.
package dm_uart_tx_pkg;

  localparam int unsigned BusWidth  = 32;
  localparam int unsigned ByteWidth = 8;
  localparam int unsigned DivWidth  = 16;

  // Register offsets, selected by address[3:2]
  localparam logic [1:0] OffTxData  = 2'd0;
  localparam logic [1:0] OffStatus  = 2'd1;
  localparam logic [1:0] OffBaudDiv = 2'd2;
  localparam logic [1:0] OffScratch = 2'd3;

  // STATUS register bit positions
  localparam int unsigned StatFull     = 0;
  localparam int unsigned StatEmpty    = 1;
  localparam int unsigned StatBusy     = 2;
  localparam int unsigned StatOverflow = 3;
  localparam int unsigned StatCountLo  = 4;
  localparam int unsigned StatCountHi  = 7;
  localparam int unsigned StatParity   = 8;

  localparam logic [DivWidth-1:0] MinDiv = 16'd2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  // A divisor below 2 cannot form a bit period; such writes are stored as 2.
  function automatic logic [DivWidth-1:0] clamp_div(input logic [DivWidth-1:0] v);
    return (v < MinDiv) ? MinDiv : v;
  endfunction

endpackage

// File: rtl/dm_uart_tx_fifo.sv
// Synchronous FIFO for the UART transmit path.
// Ports:
//   clock, reset      system clock, synchronous active-high reset (flushes pointers)
//   push, din         write request and data; ignored when full unless popping this cycle
//   pop, dout         read request and head-of-queue data (dout is combinational)
//   full, empty       occupancy flags
//   count             number of stored entries, 0..DEPTH
// Pointers carry one extra MSB so full and empty are distinguishable when the index bits match.
module dm_uart_tx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned Aw = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [Aw:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[Aw] != rd_ptr_q[Aw]) && (wr_ptr_q[Aw-1:0] == rd_ptr_q[Aw-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[Aw-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !reset) mem_q[wr_ptr_q[Aw-1:0]] <= din;
  end

endmodule

// File: rtl/dm_uart_tx.sv
// Memory-mapped UART transmitter on the CPU data-memory bus.
// Register window of 16 bytes at BASE_ADDR; reads are registered (valid the cycle after the
// address) and return 0 outside the window, so data_out can be OR-combined with Memory's.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   address        byte address; window hit when address[31:4] == BASE_ADDR[31:4]
//   width          access width; 4 honoured everywhere, 1 only at offset 0 byte 0
//   write_en       write strobe
//   data_in        write data
//   data_out       registered read data (0 for writes, misses and unsupported widths)
//   tx             serial output, idle high, 8 data bits LSB first
//   irq            level: FIFO empty and transmitter idle
// Build option: define DM_UART_PARITY_EN to insert an even-parity bit after the data bits
// (STATUS[8] then reads 1).
module dm_uart_tx
  import dm_uart_tx_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0300,
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter int unsigned DEFAULT_DIV = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [BusWidth-1:0] address,
  input  logic [3:0]          width,
  input  logic                write_en,
  input  logic [BusWidth-1:0] data_in,
  output logic [BusWidth-1:0] data_out,
  output logic                tx,
  output logic                irq
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DivWidth-1:0] ResetDiv = clamp_div(DivWidth'(DEFAULT_DIV));

`ifdef DM_UART_PARITY_EN
  localparam logic ParityEn = 1'b1;
  logic parity_q, parity_d;
`else
  localparam logic ParityEn = 1'b0;
`endif

  // Bus decode
  logic [1:0] offset;
  logic       acc_ok, wr_acc, rd_acc;

  assign offset = address[3:2];
  assign acc_ok = (address[31:4] == BASE_ADDR[31:4]) &&
                  ((width == 4'd4) ||
                   ((width == 4'd1) && (offset == OffTxData) && (address[1:0] == 2'b00)));
  assign wr_acc = acc_ok && write_en;
  assign rd_acc = acc_ok && !write_en;

  // FIFO
  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ByteWidth-1:0] fifo_dout;
  logic [CntW-1:0]      fifo_count;
  logic                 push_drop;

  assign fifo_push = wr_acc && (offset == OffTxData);
  assign push_drop = fifo_push && fifo_full && !fifo_pop;

  dm_uart_tx_fifo #(
    .WIDTH (ByteWidth),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (data_in[ByteWidth-1:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Registers
  logic                overflow_q, overflow_d;
  logic [DivWidth-1:0] baud_div_q, baud_div_d;
  logic [BusWidth-1:0] scratch_q, scratch_d;
  logic [BusWidth-1:0] data_out_q, data_out_d;

  // Transmitter
  tx_state_e            state_q, state_d;
  logic [DivWidth-1:0]  cnt_q, cnt_d;
  logic [ByteWidth-1:0] shift_q, shift_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic                 tx_q, tx_d;
  logic                 busy;

  assign busy = (state_q != StIdle);

  always_comb begin
    overflow_d = overflow_q;
    baud_div_d = baud_div_q;
    scratch_d  = scratch_q;
    if (push_drop) overflow_d = 1'b1;
    if (wr_acc) begin
      case (offset)
        OffStatus:  if (data_in[StatOverflow]) overflow_d = 1'b0;
        OffBaudDiv: baud_div_d = clamp_div(data_in[DivWidth-1:0]);
        OffScratch: scratch_d = data_in;
        default:    ;
      endcase
    end
  end

  // Read path
  logic [BusWidth-1:0] status;
  logic [BusWidth-1:0] count_ext;

  always_comb begin
    count_ext = BusWidth'(fifo_count);
    status    = '0;
    status[StatFull]     = fifo_full;
    status[StatEmpty]    = fifo_empty;
    status[StatBusy]     = busy;
    status[StatOverflow] = overflow_q;
    status[StatCountHi:StatCountLo] = (count_ext > 32'd15) ? 4'hF : count_ext[3:0];
    status[StatParity]   = ParityEn;
  end

  always_comb begin
    data_out_d = '0;
    if (rd_acc) begin
      case (offset)
        OffStatus:  data_out_d = status;
        OffBaudDiv: data_out_d = {16'h0, baud_div_q};
        OffScratch: data_out_d = scratch_q;
        default:    data_out_d = '0;
      endcase
    end
  end

  // TX FSM: each state lasts baud_div_q clocks; the divisor is sampled at every bit boundary
  // so a new BAUD_DIV only affects the following bit.
  logic                bit_done, load;
  logic [DivWidth-1:0] reload;

  assign bit_done = (cnt_q == '0);
  assign reload   = baud_div_q - 16'd1;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q - 16'd1;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    fifo_pop  = 1'b0;
    load      = 1'b0;
`ifdef DM_UART_PARITY_EN
    parity_d  = parity_q;
`endif

    unique case (state_q)
      StIdle: begin
        cnt_d = cnt_q;
        if (!fifo_empty) load = 1'b1;
      end
      StStart: begin
        if (bit_done) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
          cnt_d     = reload;
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d = reload;
          if (bit_idx_q == 3'd7) begin
            state_d = ParityEn ? StParity : StStop;
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_done) begin
          state_d = StStop;
          cnt_d   = reload;
        end
      end
      StStop: begin
        if (bit_done) begin
          if (!fifo_empty) load = 1'b1;
          else state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Back-to-back frames go straight from STOP to START without an idle cycle.
    if (load) begin
      fifo_pop = 1'b1;
      state_d  = StStart;
      shift_d  = fifo_dout;
      cnt_d    = reload;
`ifdef DM_UART_PARITY_EN
      parity_d = ^fifo_dout;
`endif
    end

    // tx is registered from the next state so it changes exactly at the bit boundary.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef DM_UART_PARITY_EN
      StParity: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
      baud_div_q <= ResetDiv;
      scratch_q  <= '0;
      data_out_q <= '0;
      state_q    <= StIdle;
      cnt_q      <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      tx_q       <= 1'b1;
`ifdef DM_UART_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      overflow_q <= overflow_d;
      baud_div_q <= baud_div_d;
      scratch_q  <= scratch_d;
      data_out_q <= data_out_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      tx_q       <= tx_d;
`ifdef DM_UART_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign data_out = data_out_q;
  assign tx       = tx_q;
  assign irq      = fifo_empty && !busy;

endmodule

// File: tb/tb_dm_uart_tx.sv
// Bench for dm_uart_tx: frame-level reference model checked every cycle, directed scenarios
// with hand-computed expectations, then randomized bus traffic.
module tb_dm_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_0300;
  localparam int          DEPTH = 8;
`ifdef DM_UART_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam logic [31:0] SPAR = PAR ? 32'h100 : 32'h0;
  localparam int          NB   = PAR ? 11 : 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] address = '0;
  logic [3:0]  width = '0;
  logic        write_en = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        tx, irq;

  int vectors = 0;
  int miscompares = 0;

  dm_uart_tx #(
    .BASE_ADDR   (BASE),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .address  (address),
    .width    (width),
    .write_en (write_en),
    .data_in  (data_in),
    .data_out (data_out),
    .tx       (tx),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [7:0]  q[$];
  bit          ovf, busy_m, m_valid = 1'b0;
  logic [15:0] mdiv;
  logic [31:0] scr, m_dout;
  logic [10:0] fb;
  int          pos, remain;
  logic        m_tx, m_irq;

  task automatic model_step();
    logic [31:0] rd;
    logic        ok;
    logic [7:0]  b;
    if (reset) begin
      q.delete();
      ovf = 0; busy_m = 0; mdiv = 16; scr = 0; m_dout = 0;
      m_tx = 1; m_irq = 1; m_valid = 1;
      return;
    end
    ok = (address[31:4] == BASE[31:4]) &&
         ((width == 4'd4) || (width == 4'd1 && address[3:0] == 4'h0));
    rd = 0;
    if (ok && !write_en) begin
      case (address[3:2])
        2'd1: rd = {23'b0, PAR, (q.size() > 15 ? 4'hF : 4'(q.size())), ovf, busy_m,
                    q.size() == 0, q.size() == DEPTH};
        2'd2: rd = {16'b0, mdiv};
        2'd3: rd = scr;
        default: rd = 0;
      endcase
    end
    m_dout = rd;
    // Each frame bit lasts the divisor in force when that bit began.
    if (busy_m) begin
      remain--;
      if (remain == 0) begin
        pos++;
        if (pos == NB) busy_m = 0;
        else remain = int'(mdiv);
      end
    end
    if (!busy_m && q.size() > 0) begin
      b  = q.pop_front();
      fb = PAR ? {1'b1, ^b, b, 1'b0} : {2'b11, b, 1'b0};
      pos = 0; remain = int'(mdiv); busy_m = 1;
    end
    m_tx = busy_m ? fb[pos] : 1'b1;
    if (ok && write_en) begin
      case (address[3:2])
        2'd0: if (q.size() < DEPTH) q.push_back(data_in[7:0]); else ovf = 1;
        2'd1: if (data_in[3]) ovf = 0;
        2'd2: mdiv = (data_in[15:0] < 16'd2) ? 16'd2 : data_in[15:0];
        default: scr = data_in;
      endcase
    end
    m_irq = (q.size() == 0) && !busy_m;
  endtask

  always @(posedge clock) model_step();

  always @(negedge clock) begin
    if (m_valid) begin
      check("model_tx", {31'b0, tx}, {31'b0, m_tx});
      check("model_irq", {31'b0, irq}, {31'b0, m_irq});
      check("model_data_out", data_out, m_dout);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_bus();
    address = '0; width = '0; write_en = 1'b0; data_in = '0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    address = a; width = w; write_en = 1'b1; data_in = d;
    tick();
    idle_bus();
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [3:0] w,
                          input logic [31:0] exp);
    address = a; width = w; write_en = 1'b0;
    tick();
    idle_bus();
    check(name, data_out, exp);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (irq !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'b0, irq}, 32'd1);
  endtask

  // Called right after the push edge; bits holds the frame LSB-first (start bit at index 0).
  task automatic expect_frame(input string name, input logic [10:0] bits, input int div);
    @(negedge clock);
    check({name, "_pre_tx"}, {31'b0, tx}, 32'd1);
    check({name, "_pre_irq"}, {31'b0, irq}, 32'd0);
    for (int k = 1; k <= NB * div; k++) begin
      @(negedge clock);
      check({name, "_tx"}, {31'b0, tx}, {31'b0, bits[(k - 1) / div]});
    end
    @(negedge clock);
    check({name, "_end_tx"}, {31'b0, tx}, 32'd1);
    check({name, "_end_irq"}, {31'b0, irq}, 32'd1);
    #1;
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  w;
    int          lows;

    idle_bus();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clock);
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_irq", {31'b0, irq}, 32'd1);
    check("reset_data_out", data_out, 32'd0);
    #1;

    // Register reads, misses and unsupported widths
    rd_check("t3_status", BASE + 4, 4'd4, 32'h2 | SPAR);
    wr(BASE + 12, 4'd4, 32'hDEAD_BEEF);
    rd_check("t3_scratch", BASE + 12, 4'd4, 32'hDEAD_BEEF);
    rd_check("t3_out_of_window", BASE + 16, 4'd4, 32'h0);
    rd_check("t3_width2", BASE + 4, 4'd2, 32'h0);
    rd_check("t3_width1_off8", BASE + 8, 4'd1, 32'h0);
    rd_check("t3_baud_default", BASE + 8, 4'd4, 32'd16);
    rd_check("t3_txdata_reads0", BASE, 4'd4, 32'h0);

    // 0x55 at divisor 16 (parity of 0x55 is 0)
    wr(BASE, 4'd4, 32'h55);
    expect_frame("t1", PAR ? 11'h4AA : 11'h2AA, 16);

    // Ten back-to-back pushes: first is popped into START, next eight fill, tenth dropped
    for (int i = 0; i < 10; i++) wr(BASE, 4'd4, 32'h10 + i);
    rd_check("t2_status_full_ovf", BASE + 4, 4'd4, 32'h8D | SPAR);
    wr(BASE + 4, 4'd4, 32'h8);
    rd_check("t2_status_ovf_clr", BASE + 4, 4'd4, 32'h85 | SPAR);
    wait_idle(9 * NB * 16 + 100);

    // Divisor 0 is stored as 2
    wr(BASE + 8, 4'd4, 32'h0);
    rd_check("t4_baud_clamp", BASE + 8, 4'd4, 32'd2);
    wr(BASE, 4'd1, 32'hFF);
    expect_frame("t4", PAR ? 11'h5FE : 11'h3FE, 2);

`ifdef DM_UART_PARITY_EN
    wr(BASE, 4'd4, 32'h07);
    expect_frame("t6_07", 11'h60E, 2);
    wr(BASE, 4'd4, 32'h03);
    expect_frame("t6_03", 11'h406, 2);
    rd_check("t6_status_par", BASE + 4, 4'd4, 32'h102);
`endif

    // Reset during data bit 3 of 0xA5 with three bytes queued (divisor 8)
    wr(BASE + 8, 4'd4, 32'd8);
    wr(BASE, 4'd4, 32'hA5);
    wr(BASE, 4'd4, 32'h11);
    wr(BASE, 4'd4, 32'h22);
    wr(BASE, 4'd4, 32'h33);
    repeat (33) tick();
    check("t5_bit3_low", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clock);
    check("t5_tx_after_reset", {31'b0, tx}, 32'd1);
    check("t5_irq_after_reset", {31'b0, irq}, 32'd1);
    #1;
    rd_check("t5_status", BASE + 4, 4'd4, 32'h2 | SPAR);
    rd_check("t5_baud", BASE + 8, 4'd4, 32'd16);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    check("t5_no_tx_after_reset", lows, 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      reset = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 99) < 35) begin
        idle_bus();
      end else begin
        if ($urandom_range(0, 9) < 9) a = BASE + $urandom_range(0, 15);
        else a = $urandom;
        case ($urandom_range(0, 7))
          0: w = 4'd1;
          1: w = 4'd2;
          2: w = 4'd0;
          3: w = 4'd3;
          default: w = 4'd4;
        endcase
        d = $urandom;
        if (a[3:2] == 2'd2) d[15:0] = 16'($urandom_range(0, 5));
        address = a; width = w; data_in = d;
        write_en = ($urandom_range(0, 1) == 1);
      end
      tick();
    end
    reset = 1'b0;
    idle_bus();
    wait_idle(3000);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
